usart_rx: RTL and testbench

Serial-to-parallel receiver for the USART link: the receive-side counterpart of the PISO transmit shifter. Samples an asynchronous 8N1 line (idle high, start low, 8 data bits LSB first, stop high) at mid-bit using a clock-cycle bit timer. Presents each received byte on an 8-bit parallel port with a valid/ready handshake, and flags framing and overrun errors.

---
 rtl/usart_pkg.sv | 24 ++
 rtl/usart_rx_sync.sv | 33 +++
 rtl/usart_rx.sv | 195 +++++++++++++++++++
 tb/tb_usart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// usart_pkg
// Shared declarations for the USART receive path.
//   rx_state_t   : receiver state encoding
//   DATA_BITS    : payload bits per frame
//   timer_width(): width of a bit timer that must count 0 .. clks_per_bit-1
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Width of the bit timer. Guarded so tiny values still give a 1-bit counter.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/usart_rx_sync.sv
// rx_sync
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Both flops reset to RESET_VAL so a line that idles at that level produces no
// spurious edge when reset is released.
//   clk : sampling clock
//   rst : asynchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output (two cycles of latency)
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/usart_rx.sv
// usart_rx
// 8N1 serial receiver (optionally 8 data + parity + stop). The line is
// synchronized, the start bit is qualified at mid-bit, and every following bit
// is sampled one bit period later. Completed bytes are offered on a
// valid/ready port; the receiver never stalls, so an unconsumed byte is
// overwritten and OVERRUN is pulsed.
//
// Build option: define RX_PARITY_EN to add the parity bit and make PAR_ERR live.
// Without it PAR_ERR is tied low.
//
// Ports:
//   CLK        : clock, rising edge
//   CLR        : asynchronous, active-high reset
//   RX_IN      : asynchronous serial line, idle high
//   DATA_OUT   : last received byte, held until the next byte is loaded
//   DATA_VALID : DATA_OUT holds an unconsumed byte
//   DATA_READY : consumer takes the byte when DATA_VALID && DATA_READY
//   FRAME_ERR  : one-cycle pulse, stop bit sampled low
//   PAR_ERR    : one-cycle pulse, parity mismatch (byte still delivered)
//   OVERRUN    : one-cycle pulse, an unconsumed byte was overwritten
module usart_rx
  import usart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RX_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  input  logic       DATA_READY,
  output logic       FRAME_ERR,
  output logic       PAR_ERR,
  output logic       OVERRUN
);

  localparam int TW   = timer_width(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BCW  = $clog2(DATA_BITS);

  // Timer values seen on the edge where a sample is taken.
  localparam logic [TW-1:0]  HALF_LAST = TW'(HALF - 1);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] CNT_LAST  = BCW'(DATA_BITS - 1);

  // Reject parameter values the timing scheme cannot honour.
  if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("usart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD 0 or 1");
  end

  logic                 rxs;
  rx_state_t            state_reg;
  logic [TW-1:0]        timer_reg;
  logic [BCW-1:0]       bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 done_reg;     // a frame ended on the previous edge
  logic                 stop_ok_reg;  // its stop bit was high
  logic                 accept;

`ifdef RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_bad_reg;
`endif

  rx_sync #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk (CLK),
    .rst (CLR),
    .d   (RX_IN),
    .q   (rxs)
  );

  assign accept = DATA_VALID && DATA_READY;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      done_reg    <= 1'b0;
      stop_ok_reg <= 1'b0;
      DATA_OUT    <= '0;
      DATA_VALID  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      OVERRUN     <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_reg <= 1'b0;
      PAR_ERR     <= 1'b0;
`endif
    end else begin
      done_reg  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef RX_PARITY_EN
      PAR_ERR   <= 1'b0;
`endif
      timer_reg <= timer_reg + 1'b1;

      // ---------------- frame sequencing ----------------
      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          if (!rxs) begin
            state_reg <= START;
          end
        end

        START: begin
          if (timer_reg == HALF_LAST) begin
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            // A line already back high at mid-start is a glitch.
            state_reg   <= rxs ? IDLE : DATA;
          end
        end

        DATA: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg   <= '0;
            shift_reg   <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CNT_LAST) begin
`ifdef RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end
        end

`ifdef RX_PARITY_EN
        PARITY: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg   <= '0;
            // Received bit versus the bit the sender should have appended.
            par_bad_reg <= rxs ^ (^shift_reg) ^ PAR_SENSE;
            state_reg   <= STOP;
          end
        end
`endif

        STOP: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg   <= '0;
            done_reg    <= 1'b1;
            stop_ok_reg <= rxs;
            // Returning to IDLE right away lets a back-to-back start bit be
            // caught; a low stop bit may be a break, so wait for the line.
            state_reg   <= rxs ? IDLE : WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          timer_reg <= '0;
          if (rxs) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      // ---------------- output handshake ----------------
      // Result of the stop sample is applied one edge later, so all status
      // outputs line up on the same registered edge.
      if (done_reg && stop_ok_reg) begin
        DATA_OUT   <= shift_reg;
        DATA_VALID <= 1'b1;
        // Taken in this same cycle means nothing was lost.
        OVERRUN    <= DATA_VALID && !DATA_READY;
`ifdef RX_PARITY_EN
        PAR_ERR    <= par_bad_reg;
`endif
      end else begin
        if (done_reg) begin
          FRAME_ERR <= 1'b1;
        end
        if (accept) begin
          DATA_VALID <= 1'b0;
        end
      end
    end
  end

`ifndef RX_PARITY_EN
  assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx
// Directed bench for usart_rx with CLKS_PER_BIT = 16. A negedge monitor counts
// DATA_VALID rises, high cycles and error pulses; each scenario compares the
// change in those counts and the port values against hand-computed numbers.
module tb_usart_rx;

  localparam int CPB        = 16;
  localparam int PARITY_ODD = 0;
`ifdef RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Drive start at a negedge with cycle count n: two sync flops, then IDLE sees
  // it at edge n+3 (t0). Stop sample at t0+8+9*16 (+16 with parity), outputs
  // one edge later: n + 3 + 8 + 144 + 1 = n + 156 for 8N1.
  localparam int VALID_LAT  = 156 + PAR_BITS * CPB;

  logic       clk = 1'b0;
  logic       clr;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       par_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dv_rises = 0, dv_high = 0, dv_rise_cyc = -1;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic dv_prev = 1'b0;

  int s_rises, s_high, s_fe, s_ov, s_pe;
  int start_cyc;

  usart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .CLK       (clk),
    .CLR       (clr),
    .RX_IN     (rx_in),
    .DATA_OUT  (data_out),
    .DATA_VALID(data_valid),
    .DATA_READY(data_ready),
    .FRAME_ERR (frame_err),
    .PAR_ERR   (par_err),
    .OVERRUN   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!clr) begin
      if (data_valid && !dv_prev) begin
        dv_rises    = dv_rises + 1;
        dv_rise_cyc = cyc;
      end
      if (data_valid) dv_high = dv_high + 1;
      if (frame_err)  fe_cnt  = fe_cnt + 1;
      if (overrun)    ov_cnt  = ov_cnt + 1;
      if (par_err)    pe_cnt  = pe_cnt + 1;
    end
    dv_prev = data_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic snap();
    s_rises = dv_rises;
    s_high  = dv_high;
    s_fe    = fe_cnt;
    s_ov    = ov_cnt;
    s_pe    = pe_cnt;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    wait_cycles(CPB);
  endtask

  // Start, 8 data bits LSB first, optional parity, stop. Line is left at the
  // stop level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RX_PARITY_EN
    drive_bit((^b) ^ (PARITY_ODD != 0) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    logic [7:0] abort_byte;
    int exp_rise;

    clr        = 1'b1;
    rx_in      = 1'b1;
    data_ready = 1'b1;
    wait_cycles(4);

    // ---- reset state ----
    check_eq("rst_data_out",   32'(data_out),   32'h0);
    check_eq("rst_data_valid", 32'(data_valid), 32'h0);
    check_eq("rst_frame_err",  32'(frame_err),  32'h0);
    check_eq("rst_overrun",    32'(overrun),    32'h0);
    check_eq("rst_par_err",    32'(par_err),    32'h0);
    clr = 1'b0;
    wait_cycles(4);

    // ---- clean 0x0A ----
    snap();
    send_frame(8'h0A, 1'b1, 1'b0);
    exp_rise = start_cyc + VALID_LAT;
    wait_cycles(30);
    check_eq("b0a_data",      32'(data_out),        32'h0A);
    check_eq("b0a_rises",     32'(dv_rises - s_rises), 32'd1);
    check_eq("b0a_rise_cyc",  32'(dv_rise_cyc),     32'(exp_rise));
    check_eq("b0a_valid_len", 32'(dv_high - s_high), 32'd1);
    check_eq("b0a_fe",        32'(fe_cnt - s_fe),   32'd0);
    check_eq("b0a_ov",        32'(ov_cnt - s_ov),   32'd0);
    check_eq("b0a_pe",        32'(pe_cnt - s_pe),   32'd0);

    // ---- 5-cycle glitch, then a real byte ----
    snap();
    rx_in = 1'b0;
    wait_cycles(5);
    rx_in = 1'b1;
    wait_cycles(40);
    check_eq("glitch_rises", 32'(dv_rises - s_rises), 32'd0);
    check_eq("glitch_fe",    32'(fe_cnt - s_fe),      32'd0);
    check_eq("glitch_valid", 32'(data_valid),         32'h0);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    exp_rise = start_cyc + VALID_LAT;
    wait_cycles(30);
    check_eq("b5a_data",     32'(data_out),           32'h5A);
    check_eq("b5a_rises",    32'(dv_rises - s_rises), 32'd1);
    check_eq("b5a_rise_cyc", 32'(dv_rise_cyc),        32'(exp_rise));

    // ---- 0x55 with low stop, then a held break ----
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cycles(400);
    rx_in = 1'b1;
    wait_cycles(40);
    check_eq("brk_fe",    32'(fe_cnt - s_fe),      32'd1);
    check_eq("brk_rises", 32'(dv_rises - s_rises), 32'd0);
    check_eq("brk_data",  32'(data_out),           32'h5A);

    // ---- overrun: 0x11 then 0x22 with no consumer ----
    data_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cycles(20);
    check_eq("ovr_data",  32'(data_out),           32'h22);
    check_eq("ovr_cnt",   32'(ov_cnt - s_ov),      32'd1);
    check_eq("ovr_rises", 32'(dv_rises - s_rises), 32'd1);
    check_eq("ovr_valid", 32'(data_valid),         32'h1);
    data_ready = 1'b1;
    wait_cycles(1);
    check_eq("ovr_taken", 32'(data_valid),         32'h0);

    // ---- reset during bit 4 of 0xF0, then 0x3C ----
    abort_byte = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx_in = abort_byte[4];
    wait_cycles(8);
    clr = 1'b1;
    rx_in = 1'b1;
    wait_cycles(3);
    clr = 1'b0;
    snap();
    wait_cycles(200);
    check_eq("abort_rises", 32'(dv_rises - s_rises), 32'd0);
    check_eq("abort_fe",    32'(fe_cnt - s_fe),      32'd0);
    check_eq("abort_data",  32'(data_out),           32'h0);
    snap();
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cycles(30);
    check_eq("b3c_data",  32'(data_out),           32'h3C);
    check_eq("b3c_rises", 32'(dv_rises - s_rises), 32'd1);

`ifdef RX_PARITY_EN
    // ---- parity: correct, then flipped ----
    snap();
    send_frame(8'h0A, 1'b1, 1'b0);
    wait_cycles(30);
    check_eq("par_ok_data", 32'(data_out),         32'h0A);
    check_eq("par_ok_pe",   32'(pe_cnt - s_pe),    32'd0);
    snap();
    send_frame(8'h0A, 1'b1, 1'b1);
    wait_cycles(30);
    check_eq("par_bad_data",  32'(data_out),           32'h0A);
    check_eq("par_bad_rises", 32'(dv_rises - s_rises), 32'd1);
    check_eq("par_bad_pe",    32'(pe_cnt - s_pe),      32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
